mem_stage: RTL and testbench



---
 rtl/mem_stage.sv | 108 ++++++++++
 tb/tb_mem_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: splits each 32-bit load/store into two 16-bit accesses to an
// asynchronous SRAM with WAIT_CYCLES extra wait cycles per half-word.
module mem_stage #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_r_en_i,
    input  logic        mem_w_en_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] val_rm_i,
    output logic        ready_o,
    output logic [31:0] mem_read_value_o,
    output logic [17:0] sram_addr_o,
    output logic [15:0] sram_wdata_o,
    input  logic [15:0] sram_rdata_i,
    output logic        sram_we_n_o,
    output logic        sram_ce_n_o
);

    typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

    localparam logic [2:0] WaitLast = 3'(WAIT_CYCLES);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] lo_hold_q, lo_hold_d;
    logic [31:0] mem_read_value_q, mem_read_value_d;

    logic        req;
    logic        is_store;
    logic        active;
    logic        half;
    logic        last_cnt;
    logic [16:0] word;

    assign req      = mem_r_en_i | mem_w_en_i;
    assign is_store = mem_w_en_i;
    assign last_cnt = (cnt_q == WaitLast);
    // Addresses below BASE_ADDR wrap modulo 2^17 words through the truncation.
    assign word     = 17'((alu_result_i - BASE_ADDR) >> 2);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= StIdle;
            cnt_q            <= 3'd0;
            lo_hold_q        <= 16'd0;
            mem_read_value_q <= 32'd0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            lo_hold_q        <= lo_hold_d;
            mem_read_value_q <= mem_read_value_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        lo_hold_d        = lo_hold_q;
        mem_read_value_d = mem_read_value_q;
        half             = 1'b0;
        active           = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StLo;
                    cnt_d   = 3'd0;
                end
            end
            StLo: begin
                active = 1'b1;
                if (last_cnt) begin
                    state_d = StHi;
                    cnt_d   = 3'd0;
                    if (!is_store) lo_hold_d = sram_rdata_i;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StHi: begin
                active = 1'b1;
                half   = 1'b1;
                if (last_cnt) begin
                    state_d = StDone;
                    if (!is_store) mem_read_value_d = {sram_rdata_i, lo_hold_q};
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        sram_ce_n_o  = ~active;
        sram_we_n_o  = ~(active & is_store);
        sram_addr_o  = active ? {word, half} : 18'd0;
        sram_wdata_o = 16'd0;
        if (active && is_store) sram_wdata_o = half ? val_rm_i[31:16] : val_rm_i[15:0];
    end

    assign ready_o          = ~req | (state_q == StDone);
    assign mem_read_value_o = mem_read_value_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: one DUT with WAIT_CYCLES=1, one with WAIT_CYCLES=0,
// each attached to a simple behavioural asynchronous SRAM.
module tb_mem_stage;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    // W=1 instance signals
    logic        r1, w1, ready1, we1, ce1;
    logic [31:0] alu1, val1, mrv1;
    logic [17:0] addr1;
    logic [15:0] wd1, rd1;
    // W=0 instance signals
    logic        r0, w0, ready0, we0, ce0;
    logic [31:0] alu0, val0, mrv0;
    logic [17:0] addr0;
    logic [15:0] wd0, rd0;

    bit [15:0] mem1 [0:262143];
    bit [15:0] mem0 [0:262143];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (!ce1 && !we1) mem1[addr1] <= wd1;
    always @(posedge clk) if (!ce0 && !we0) mem0[addr0] <= wd0;
    assign rd1 = mem1[addr1];
    assign rd0 = mem0[addr0];

    mem_stage #(.WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .mem_r_en_i(r1), .mem_w_en_i(w1),
        .alu_result_i(alu1), .val_rm_i(val1), .ready_o(ready1), .mem_read_value_o(mrv1),
        .sram_addr_o(addr1), .sram_wdata_o(wd1), .sram_rdata_i(rd1),
        .sram_we_n_o(we1), .sram_ce_n_o(ce1)
    );

    mem_stage #(.WAIT_CYCLES(0), .BASE_ADDR(32'd1024)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .mem_r_en_i(r0), .mem_w_en_i(w0),
        .alu_result_i(alu0), .val_rm_i(val0), .ready_o(ready0), .mem_read_value_o(mrv0),
        .sram_addr_o(addr0), .sram_wdata_o(wd0), .sram_rdata_i(rd0),
        .sram_we_n_o(we0), .sram_ce_n_o(ce0)
    );

    // Bundle layout: {ready, ce_n, we_n, addr[17:0], wdata[15:0]}
    task automatic test_reset();
        logic [36:0] exp_b;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp_b = {1'b1, 1'b1, 1'b1, 18'd0, 16'd0};
        n_checks++;
        if ({ready1, ce1, we1, addr1, wd1} !== exp_b)
            $display("FAIL reset_outputs: got %h want %h", {ready1, ce1, we1, addr1, wd1}, exp_b);
        else n_pass++;
        n_checks++;
        if (mrv1 !== 32'd0 || mrv0 !== 32'd0)
            $display("FAIL reset_mrv: got %h/%h want 0/0", mrv1, mrv0);
        else n_pass++;
        r1 = 1'b1;
        #1;
        n_checks++;
        if (ready1 !== 1'b0 || ce1 !== 1'b1)
            $display("FAIL reset_ready_req: got ready=%b ce_n=%b want 0/1", ready1, ce1);
        else n_pass++;
        r1 = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_store_w1();
        logic [36:0] exp_b;
        logic [15:0] e_wd;
        logic [17:0] e_addr;
        logic        e_act;
        w1 = 1'b1; alu1 = 32'd1024; val1 = 32'hDEADBEEF;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            e_act  = (c >= 1 && c <= 4);
            e_addr = (c >= 3 && c <= 4) ? 18'd1 : 18'd0;
            e_wd   = (c == 1 || c == 2) ? 16'hBEEF : (c == 3 || c == 4) ? 16'hDEAD : 16'h0;
            exp_b  = {(c == 5), ~e_act, ~e_act, e_addr, e_wd};
            n_checks++;
            if ({ready1, ce1, we1, addr1, wd1} !== exp_b)
                $display("FAIL store_w1 c%0d: got %h want %h", c, {ready1, ce1, we1, addr1, wd1},
                         exp_b);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        w1 = 1'b0;
        n_checks++;
        if (mem1[0] !== 16'hBEEF || mem1[1] !== 16'hDEAD)
            $display("FAIL store_w1_sram: got %h %h want beef dead", mem1[0], mem1[1]);
        else n_pass++;
    endtask

    task automatic test_load_w1();
        logic [20:0] exp_b;
        logic        e_act;
        r1 = 1'b1; alu1 = 32'd1024; val1 = 32'h0;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            e_act = (c >= 1 && c <= 4);
            exp_b = {(c == 5), ~e_act, 1'b1, (c >= 3 && c <= 4) ? 18'd1 : 18'd0};
            n_checks++;
            if ({ready1, ce1, we1, addr1} !== exp_b)
                $display("FAIL load_w1 c%0d: got %h want %h", c, {ready1, ce1, we1, addr1}, exp_b);
            else n_pass++;
            if (c == 4) begin
                n_checks++;
                if (mrv1 !== 32'd0) $display("FAIL load_w1_early: got %h want 0", mrv1);
                else n_pass++;
            end
            if (c == 5) begin
                n_checks++;
                if (mrv1 !== 32'hDEADBEEF)
                    $display("FAIL load_w1_data: got %h want deadbeef", mrv1);
                else n_pass++;
            end
            @(posedge clk);
            #1;
        end
        r1 = 1'b0;
    endtask

    task automatic test_idle();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if ({ready1, ce1, we1} !== 3'b111 || mrv1 !== 32'hDEADBEEF)
                $display("FAIL idle c%0d: got rdy/ce/we=%b mrv=%h want 111 deadbeef", c,
                         {ready1, ce1, we1}, mrv1);
            else n_pass++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [20:0] exp_b;
        logic        e_act;
        logic [17:0] e_addr;
        w0 = 1'b1; r0 = 1'b0; alu0 = 32'd1032; val0 = 32'h12345678;
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            e_act  = (c == 1 || c == 2 || c == 5 || c == 6);
            e_addr = (c == 1 || c == 5) ? 18'd4 : (c == 2 || c == 6) ? 18'd5 : 18'd0;
            exp_b  = {(c == 3 || c == 7), ~e_act, ~(c == 1 || c == 2), e_addr};
            n_checks++;
            if ({ready0, ce0, we0, addr0} !== exp_b)
                $display("FAIL b2b c%0d: got %h want %h", c, {ready0, ce0, we0, addr0}, exp_b);
            else n_pass++;
            if (c == 6 || c == 7) begin
                n_checks++;
                if (mrv0 !== ((c == 7) ? 32'h12345678 : 32'd0))
                    $display("FAIL b2b_data c%0d: got %h want %h", c, mrv0,
                             (c == 7) ? 32'h12345678 : 32'd0);
                else n_pass++;
            end
            @(posedge clk);
            #1;
            if (c == 3) begin
                w0 = 1'b0;
                r0 = 1'b1;
            end
        end
        r0 = 1'b0;
    endtask

    task automatic test_reset_mid();
        w1 = 1'b1; alu1 = 32'd1028; val1 = 32'hCAFEF00D;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            if (c < 3) begin
                @(posedge clk);
                #1;
            end
        end
        n_checks++;
        if ({ce1, we1, addr1} !== {1'b0, 1'b0, 18'd3})
            $display("FAIL rstmid_hi: got %h want %h", {ce1, we1, addr1}, {1'b0, 1'b0, 18'd3});
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ready1, ce1, we1} !== 3'b011 || mrv1 !== 32'd0)
            $display("FAIL rstmid_async: got rdy/ce/we=%b mrv=%h want 011 0", {ready1, ce1, we1},
                     mrv1);
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            n_checks++;
            if ({ready1, ce1, addr1} !== {(c == 5), ~(c >= 1 && c <= 4),
                                          (c == 3 || c == 4) ? 18'd3 : (c >= 1 && c <= 2) ? 18'd2 : 18'd0})
                $display("FAIL rstmid_restart c%0d: got %h", c, {ready1, ce1, addr1});
            else n_pass++;
            @(posedge clk);
            #1;
        end
        w1 = 1'b0;
        n_checks++;
        if (mem1[2] !== 16'hF00D || mem1[3] !== 16'hCAFE)
            $display("FAIL rstmid_sram: got %h %h want f00d cafe", mem1[2], mem1[3]);
        else n_pass++;
    endtask

    task automatic test_wrap();
        w1 = 1'b1; alu1 = 32'd1020; val1 = 32'h22221111;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1 || c == 3) begin
                n_checks++;
                if (addr1 !== ((c == 1) ? 18'h3FFFE : 18'h3FFFF))
                    $display("FAIL wrap_store c%0d: got %h want %h", c, addr1,
                             (c == 1) ? 18'h3FFFE : 18'h3FFFF);
                else n_pass++;
            end
            @(posedge clk);
            #1;
        end
        w1 = 1'b0;
        r1 = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            if (c == 2 || c == 4) begin
                n_checks++;
                if (addr1 !== ((c == 2) ? 18'h3FFFE : 18'h3FFFF))
                    $display("FAIL wrap_load c%0d: got %h want %h", c, addr1,
                             (c == 2) ? 18'h3FFFE : 18'h3FFFF);
                else n_pass++;
            end
            if (c == 5) begin
                n_checks++;
                if (mrv1 !== 32'h22221111 || ready1 !== 1'b1)
                    $display("FAIL wrap_data: got mrv=%h rdy=%b want 22221111 1", mrv1, ready1);
                else n_pass++;
            end
            @(posedge clk);
            #1;
        end
        r1 = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0;
        r1 = 1'b0; w1 = 1'b0; alu1 = 32'd0; val1 = 32'd0;
        r0 = 1'b0; w0 = 1'b0; alu0 = 32'd0; val0 = 32'd0;
        test_reset();
        test_store_w1();
        test_load_w1();
        test_idle();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
